// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, arbiter request, registered output with skid
// Responses arrive one cycle after issue; the skid absorbs the one in flight when decode stalls.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_access_req,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   input  logic [31:0] instruction_code,
   output logic [31:0] inst_addr,
   output logic        stall_pc,
   output logic        ignore_curr_inst,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        redirect_misaligned
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {BOOT, RUN, SKID} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_pc_q, resp_pc_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic [31:0] skid_inst_q, skid_inst_d;
   logic        if_valid_q, if_valid_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] if_inst_q, if_inst_d;
   logic        misaligned_q, misaligned_d;
   logic        issue;
   logic        out_free;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= BOOT;
         pc_q         <= RESET_PC;
         resp_valid_q <= 1'b0;
         resp_pc_q    <= 32'h0;
         skid_pc_q    <= 32'h0;
         skid_inst_q  <= NOP;
         if_valid_q   <= 1'b0;
         if_pc_q      <= 32'h0;
         if_inst_q    <= NOP;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         resp_valid_q <= resp_valid_d;
         resp_pc_q    <= resp_pc_d;
         skid_pc_q    <= skid_pc_d;
         skid_inst_q  <= skid_inst_d;
         if_valid_q   <= if_valid_d;
         if_pc_q      <= if_pc_d;
         if_inst_q    <= if_inst_d;
         misaligned_q <= misaligned_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      skid_pc_d    = skid_pc_q;
      skid_inst_d  = skid_inst_q;
      if_valid_d   = if_valid_q;
      if_pc_d      = if_pc_q;
      if_inst_d    = if_inst_q;
      misaligned_d = 1'b0;

      out_free     = !if_valid_q || !stall;
      issue        = (state_q == RUN) && !redirect_valid && !mem_access_req
                     && !(if_valid_q && stall);
      resp_valid_d = issue;
      resp_pc_d    = pc_q;

      if (issue) begin
         pc_d = pc_q + PC_STEP;
      end

      if (state_q == BOOT) begin
         state_d = RUN;
      end

      if (redirect_valid) begin
         pc_d         = {redirect_pc[31:2], 2'b00};
         resp_valid_d = 1'b0;
         if_valid_d   = 1'b0;
         state_d      = RUN;
         misaligned_d = |redirect_pc[1:0];
      end else if (out_free) begin
         // Skid content is older than the response in flight, so it drains first.
         if (state_q == SKID) begin
            if_valid_d = 1'b1;
            if_pc_d    = skid_pc_q;
            if_inst_d  = skid_inst_q;
            if (resp_valid_q) begin
               skid_pc_d   = resp_pc_q;
               skid_inst_d = instruction_code;
            end else begin
               state_d = RUN;
            end
         end else if (resp_valid_q) begin
            if_valid_d = 1'b1;
            if_pc_d    = resp_pc_q;
            if_inst_d  = instruction_code;
         end else begin
            if_valid_d = 1'b0;
         end
      end else if (resp_valid_q) begin
         skid_pc_d   = resp_pc_q;
         skid_inst_d = instruction_code;
         state_d     = SKID;
      end
   end

   assign inst_addr           = pc_q;
   assign stall_pc            = !issue;
   assign ignore_curr_inst    = !resp_valid_q || redirect_valid;
   assign if_valid            = if_valid_q;
   assign if_pc               = if_pc_q;
   assign if_inst             = if_inst_q;
   assign redirect_misaligned = misaligned_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the single-port RISC-V core. It sits directly upstream of the instruction/data memory arbiter and owns the program counter. It drives the fetch address, the PC-stall indication and the ignore flag into the arbiter, and it receives the arbitrated instruction word back. The arbiter's memory has a synchronous 1-cycle read latency. Fetched instructions go to decode through a registered output with a one-entry skid buffer.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
PC_STEP, 4, PC increment per issued fetch; fixed for RV32I without compressed instructions.

Ports:
clk  input  1  core clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
mem_access_req  input  1  data stage owns memory this cycle; fetch must not issue
redirect_valid  input  1  branch/jump taken; load redirect_pc
redirect_pc  input  32  redirect target
stall  input  1  decode cannot accept if_inst this cycle
instruction_code  input  32  word from arbiter for the address presented in the previous cycle
inst_addr  output  32  fetch address to arbiter (= pc_q)
stall_pc  output  1  1 when pc_q does not advance this cycle
ignore_curr_inst  output  1  instruction_code this cycle must be discarded
if_valid  output  1  if_inst/if_pc hold a valid instruction for decode
if_pc  output  32  PC of if_inst
if_inst  output  32  instruction to decode
redirect_misaligned  output  1  registered pulse; redirect_pc[1:0] != 0

Behaviour:
- Reset (async, rst_n=0) sets:
  - pc_q = RESET_PC; resp_valid_q = 0; skid empty
  - if_valid = 0; if_pc = 0; if_inst = 32'h0000_0013 (NOP)
  - redirect_misaligned = 0; state = BOOT
- FSM states:
  - BOOT: exactly one cycle after reset release; no issue; then RUN.
  - RUN: skid empty.
  - SKID: skid full. Returns to RUN when the output register drains (stall=0). Goes to RUN on redirect.
- Issue condition: issue = (state==RUN) && !redirect_valid && !mem_access_req && !(if_valid && stall).
  - issue=1: pc_q <= pc_q + PC_STEP. Wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
  - stall_pc = !issue.
- Redirect has highest priority after reset:
  - pc_q <= {redirect_pc[31:2],2'b00}
  - resp_valid_q <= 0; skid cleared; if_valid <= 0
  - state <= RUN; redirect_misaligned <= |redirect_pc[1:0] for one cycle
- Response tracking:
  - resp_valid_q <= issue; resp_pc_q <= pc_q.
  - ignore_curr_inst = !resp_valid_q || redirect_valid (combinational).
  - Latency: an instruction at address A presented in cycle N appears on if_inst at cycle N+2 when there is no stall.
- Output/skid update, each cycle without redirect. Let r = resp_valid_q.
  - if_valid=0 or stall=0, skid empty: if_* <= response when r, else if_valid <= 0.
  - if_valid=0 or stall=0, skid full: if_* <= skid; skid <= response when r, else skid empties.
  - stall=1 and if_valid=1: if_* holds; if r, the response goes to skid (state SKID).
  - A response never arrives while the skid is full, because issue is blocked in SKID.
- mem_access_req=1 and stall=1 in the same cycle: no issue, output holds, in-flight response goes to skid.
- Reset asserted mid-operation: all state clears immediately; in-flight response is dropped.

Test Plan:
1. Reset, RESET_PC=0, no stalls for 6 cycles.
   - Required: inst_addr 0,0,4,8,C; if_valid first rises with if_pc=0 two cycles after BOOT; if_pc then increments by 4 each cycle.
2. Hold mem_access_req=1 for 2 cycles at pc_q=8.
   - Required: inst_addr stays 8 and stall_pc=1 for those cycles; ignore_curr_inst=1 the following cycles; no duplicate or missing if_pc values.
3. stall=1 for 3 cycles while if_pc=4 and fetch of 8 in flight.
   - Required: if_pc holds 4; 8 captured in skid; inst_addr frozen at C.
   - On release: if_pc=8 next cycle, then C.
4. redirect_valid=1, redirect_pc=32'h100 while skid full.
   - Required: skid and if_valid cleared; next inst_addr=100; ignore_curr_inst=1 that cycle; first new if_pc=100.
5. redirect_pc=32'h202 -> redirect_misaligned pulses 1 for one cycle; inst_addr=200.
6. Redirect to 32'hFFFF_FFFC, run 3 cycles -> inst_addr wraps to 0 then 4. Then assert rst_n=0 mid-stream -> outputs immediately return to reset values.
